// File: rtl/partial_store_if.sv
// Store request and memory write-beat channels shared by partial_store and its driver.
// slave modport is the store unit; master modport is execute stage plus memory side.
interface partial_store_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instruction;
    logic [31:0]           store_data;
    logic [ADDR_WIDTH-1:0] store_addr;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic [3:0]            mem_we;
    logic                  misaligned;
    logic                  store_err;

    modport slave (
        input  in_valid, instruction, store_data, store_addr, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_din, mem_we, misaligned, store_err
    );

    modport master (
        output in_valid, instruction, store_data, store_addr, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_din, mem_we, misaligned, store_err
    );
endinterface

// File: rtl/partial_store.sv
// Store lane aligner: turns SB/SH/SW into word-aligned beats with byte enables; MISALIGNED_SPLIT_EN splits word-crossing stores.
// Latency: beat 0 registered one cycle after accept; split stores add a second beat the cycle after beat 0 retires.
// Backpressure: beat outputs hold while mem_ready=0; in_ready only when idle or the last pending beat retires.
module partial_store #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    partial_store_if.slave  bus
);
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] FNC_SB    = 3'b000;
    localparam logic [2:0] FNC_SH    = 3'b001;
    localparam logic [2:0] FNC_SW    = 3'b010;

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`else
    typedef enum logic [1:0] {IDLE, BEAT0} state_t;
`endif

    state_t                state;
    logic                  mem_valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_din_q;
    logic [3:0]            mem_we_q;
    logic                  misaligned_q;
    logic                  store_err_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_store;
    logic        f3_ok;
    logic [3:0]  base;
    logic [31:0] data_m;
    logic [7:0]  we_wide;
    logic [3:0]  we_lo;
    logic [3:0]  we_hi;
    logic        crossing;
    logic [31:0] din_lo;
    logic        in_ready;
    logic        accept;
    logic        unused_instr_bits;

    assign opcode   = bus.instruction[6:0];
    assign funct3   = bus.instruction[14:12];
    assign off      = bus.store_addr[1:0];
    assign is_store = (opcode == OPC_STORE);
    assign unused_instr_bits = ^{bus.instruction[31:15], bus.instruction[11:7]};

    always_comb begin
        base   = 4'h0;
        data_m = 32'h0;
        f3_ok  = 1'b1;
        case (funct3)
            FNC_SB: begin base = 4'h1; data_m = {24'h0, bus.store_data[7:0]};  end
            FNC_SH: begin base = 4'h3; data_m = {16'h0, bus.store_data[15:0]}; end
            FNC_SW: begin base = 4'hF; data_m = bus.store_data;                end
            default: f3_ok = 1'b0;
        endcase
    end

    assign we_wide  = {4'h0, base} << off;
    assign we_lo    = we_wide[3:0];
    assign we_hi    = we_wide[7:4];
    assign crossing = |we_hi;
    assign din_lo   = data_m << {off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    logic        split_q;
    logic [3:0]  we_hi_q;
    logic [31:0] din_hi_q;
    logic [31:0] din_hi;

    // Bytes shifted past lane 3 land in the next word; off=0 shifts by 32 and yields 0.
    assign din_hi = data_m >> (6'd32 - {1'b0, off, 3'b000});
`endif

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
            BEAT0: in_ready = bus.mem_ready && !split_q;
            BEAT1: in_ready = bus.mem_ready;
`else
            BEAT0: in_ready = bus.mem_ready;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= 32'h0;
            mem_we_q     <= 4'h0;
            misaligned_q <= 1'b0;
            store_err_q  <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            split_q      <= 1'b0;
            we_hi_q      <= 4'h0;
            din_hi_q     <= 32'h0;
`endif
        end else begin
            misaligned_q <= 1'b0;
            store_err_q  <= 1'b0;

            if (mem_valid_q && bus.mem_ready) begin
`ifdef MISALIGNED_SPLIT_EN
                if (state == BEAT0 && split_q) begin
                    state      <= BEAT1;
                    mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
                    mem_we_q   <= we_hi_q;
                    mem_din_q  <= din_hi_q;
                    split_q    <= 1'b0;
                end else
`endif
                begin
                    state       <= IDLE;
                    mem_valid_q <= 1'b0;
                    mem_we_q    <= 4'h0;
                end
            end

            // Acceptance only happens when nothing remains pending, so it may override the retire above.
            if (accept && is_store) begin
                if (!f3_ok) begin
                    store_err_q <= 1'b1;
                end
`ifndef MISALIGNED_SPLIT_EN
                else if (crossing) begin
                    misaligned_q <= 1'b1;
                end
`endif
                else begin
                    state       <= BEAT0;
                    mem_valid_q <= 1'b1;
                    mem_addr_q  <= {bus.store_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_we_q    <= we_lo;
                    mem_din_q   <= din_lo;
`ifdef MISALIGNED_SPLIT_EN
                    split_q     <= crossing;
                    we_hi_q     <= we_hi;
                    din_hi_q    <= din_hi;
`endif
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.misaligned = misaligned_q;
    assign bus.store_err  = store_err_q;
endmodule

// File: tb/tb_partial_store.sv
// Bench for partial_store: byte-level reference model of expected beats and flags, compared every cycle,
// plus directed vectors with literal expectations. Honours MISALIGNED_SPLIT_EN like the design.
module tb_partial_store;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    partial_store_if #(.ADDR_WIDTH(32)) bus();
    partial_store #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } beat_t;

    beat_t q[$];
    bit    exp_mis = 1'b0;
    bit    exp_err = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {17'h0, f3, 5'h0, 7'b0100011};
    endfunction

    // Expected beats from individual bytes: each byte goes to address+k, grouped by the word it falls in.
    function automatic void model_accept(input logic [31:0] instr, input logic [31:0] data,
                                         input logic [31:0] addr);
        int          n;
        int          nb;
        beat_t       b[2];
        logic [31:0] first_word;
        logic [31:0] ba;
        logic [31:0] w;
        logic [1:0]  lane;
        int          idx;
        if (instr[6:0] != 7'b0100011) return;
        case (instr[14:12])
            3'b000:  n = 1;
            3'b001:  n = 2;
            3'b010:  n = 4;
            default: begin exp_err = 1'b1; return; end
        endcase
        for (int i = 0; i < 2; i++) begin
            b[i].addr = 32'h0; b[i].we = 4'h0; b[i].din = 32'h0;
        end
        first_word = addr & ~32'h3;
        nb = 1;
        for (int k = 0; k < n; k++) begin
            ba   = addr + 32'(k);
            w    = ba & ~32'h3;
            lane = ba[1:0];
            idx  = (w == first_word) ? 0 : 1;
            if (idx == 1) nb = 2;
            b[idx].addr = w;
            b[idx].we[lane] = 1'b1;
            b[idx].din[8*lane +: 8] = data[8*k +: 8];
        end
`ifdef MISALIGNED_SPLIT_EN
        q.push_back(b[0]);
        if (nb == 2) q.push_back(b[1]);
`else
        if (nb == 2) exp_mis = 1'b1;
        else q.push_back(b[0]);
`endif
    endfunction

    always @(negedge clk) begin
        cmp("mem_valid", 32'(bus.mem_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            cmp("mem_addr", bus.mem_addr, q[0].addr);
            cmp("mem_we", 32'(bus.mem_we), 32'(q[0].we));
            cmp("mem_din", bus.mem_din, q[0].din);
        end else begin
            cmp("mem_we_idle", 32'(bus.mem_we), 32'h0);
        end
        cmp("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || (bus.mem_ready && q.size() == 1)));
        cmp("misaligned", 32'(bus.misaligned), 32'(exp_mis));
        cmp("store_err", 32'(bus.store_err), 32'(exp_err));
        exp_mis = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() != 0 && bus.mem_ready) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready)
                model_accept(bus.instruction, bus.store_data, bus.store_addr);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] instr, input logic [31:0] data,
                        input logic [31:0] addr, output int waits);
        logic acc;
        bus.in_valid    = 1'b1;
        bus.instruction = instr;
        bus.store_data  = data;
        bus.store_addr  = addr;
        waits = 0;
        acc   = 1'b0;
        do begin
            @(negedge clk);
            waits++;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end while (!acc && waits < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never seen for addr %h", addr);
        end
        bus.in_valid    = 1'b0;
        bus.instruction = 32'h0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int w;
    logic [31:0] rst_addr;

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.instruction = 32'h0;
        bus.store_data  = 32'h0;
        bus.store_addr  = 32'h0;
        bus.mem_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_valid", 32'(bus.mem_valid), 32'h0);
        cmp("rst_addr", bus.mem_addr, 32'h0);
        cmp("rst_din", bus.mem_din, 32'h0);
        cmp("rst_we", 32'(bus.mem_we), 32'h0);
        cmp("rst_ready", 32'(bus.in_ready), 32'h1);
        step();
        rst = 1'b0;
        step();

        send(mk(3'b000), 32'h12345678, 32'h101, w);
        @(negedge clk);
        cmp("sb_addr", bus.mem_addr, 32'h100);
        cmp("sb_we", 32'(bus.mem_we), 32'h2);
        cmp("sb_din", 32'(bus.mem_din[15:8]), 32'h78);
        step();

        send(mk(3'b001), 32'h0000CDEF, 32'h202, w);
        @(negedge clk);
        cmp("sh_addr", bus.mem_addr, 32'h200);
        cmp("sh_we", 32'(bus.mem_we), 32'hC);
        cmp("sh_din", 32'(bus.mem_din[31:16]), 32'hCDEF);
        step();

        send(mk(3'b010), 32'h89ABCDEF, 32'h303, w);
        @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
        cmp("sw_b0_addr", bus.mem_addr, 32'h300);
        cmp("sw_b0_we", 32'(bus.mem_we), 32'h8);
        cmp("sw_b0_din", 32'(bus.mem_din[31:24]), 32'hEF);
        step();
        @(negedge clk);
        cmp("sw_b1_addr", bus.mem_addr, 32'h304);
        cmp("sw_b1_we", 32'(bus.mem_we), 32'h7);
        cmp("sw_b1_din", 32'(bus.mem_din[23:0]), 32'h89ABCD);
`else
        cmp("sw_mis_pulse", 32'(bus.misaligned), 32'h1);
        cmp("sw_mis_novalid", 32'(bus.mem_valid), 32'h0);
`endif
        step();

        bus.mem_ready = 1'b0;
        send(mk(3'b010), 32'hA5A55A5A, 32'h400, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("bp_valid", 32'(bus.mem_valid), 32'h1);
            cmp("bp_addr", bus.mem_addr, 32'h400);
            cmp("bp_din", bus.mem_din, 32'hA5A55A5A);
            cmp("bp_in_ready", 32'(bus.in_ready), 32'h0);
            step();
        end
        bus.mem_ready = 1'b1;
        step();
        @(negedge clk);
        cmp("bp_retired", 32'(bus.mem_valid), 32'h0);
        step();

        for (int i = 0; i < 4; i++) begin
            send(mk(3'b010), 32'hC0DE0000 + 32'(i), 32'h500 + 32'(4 * i), w);
            cmp("b2b_waits", 32'(w), 32'h1);
        end
        step();

        send(mk(3'b011), 32'hDEADBEEF, 32'h600, w);
        @(negedge clk);
        cmp("bad_f3_err", 32'(bus.store_err), 32'h1);
        cmp("bad_f3_novalid", 32'(bus.mem_valid), 32'h0);
        step();
        send(32'h0, 32'hFFFFFFFF, 32'h700, w);
        @(negedge clk);
        cmp("nonstore_err", 32'(bus.store_err), 32'h0);
        cmp("nonstore_mis", 32'(bus.misaligned), 32'h0);
        cmp("nonstore_valid", 32'(bus.mem_valid), 32'h0);
        step();

`ifdef MISALIGNED_SPLIT_EN
        rst_addr = 32'hFFFFFFFD;
`else
        rst_addr = 32'h800;
`endif
        bus.mem_ready = 1'b0;
        send(mk(3'b010), 32'h11223344, rst_addr, w);
        @(negedge clk);
        cmp("pre_rst_valid", 32'(bus.mem_valid), 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        cmp("post_rst_valid", 32'(bus.mem_valid), 32'h0);
        cmp("post_rst_ready", 32'(bus.in_ready), 32'h1);
        cmp("post_rst_addr", bus.mem_addr, 32'h0);
        bus.mem_ready = 1'b1;
        step();

        send(mk(3'b010), 32'h11223344, 32'hFFFFFFFD, w);
        @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
        cmp("wrap_b0_addr", bus.mem_addr, 32'hFFFFFFFC);
        cmp("wrap_b0_din", bus.mem_din, 32'h22334400);
        step();
        @(negedge clk);
        cmp("wrap_b1_addr", bus.mem_addr, 32'h0);
        cmp("wrap_b1_we", 32'(bus.mem_we), 32'h1);
`else
        cmp("wrap_mis_pulse", 32'(bus.misaligned), 32'h1);
`endif
        step();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
